instruction_sequencer: RTL

Control FSM that drives the program counter. It reads the instruction word that instruction memory returns for the current PC address, decodes it, and drives the counter's `inc`, `w_en`, `data_in` and `complete` inputs. Datapath operations are handed to the convolution datapath through a start/done handshake. The block sits between instruction memory and the PC, and closes the fetch loop for the image-convolution processor.

---
 rtl/instruction_sequencer_if.sv | 25 ++
 rtl/instruction_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/instruction_sequencer_if.sv
// Sequencer bundle: start/fetch inputs, PC control outputs and the datapath OP handshake.
// Every signal is a single-cycle wire; the only flow control is the op_start/op_done pair.
interface instruction_sequencer_if;
  logic        en;
  logic [31:0] instr_in;
  logic        op_done;
  logic        inc;
  logic        w_en;
  logic [31:0] data_in;
  logic        complete;
  logic        op_start;
  logic [3:0]  op_code;
  logic [23:0] op_arg;
  logic        error;

  modport master (
    input  en, instr_in, op_done,
    output inc, w_en, data_in, complete, op_start, op_code, op_arg, error
  );

  modport slave (
    output en, instr_in, op_done,
    input  inc, w_en, data_in, complete, op_start, op_code, op_arg, error
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetch/decode FSM that steers the PC and launches datapath OPs: 2 cycles per control
// instruction, 3+k per OP; stalls in WAIT until op_done.
module instruction_sequencer #(
  parameter int LOOP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  instruction_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_OP   = 4'h1;
  localparam logic [3:0] OPC_JMP  = 4'h2;
  localparam logic [3:0] OPC_JNZ  = 4'h3;
  localparam logic [3:0] OPC_LDC  = 4'h4;
  localparam logic [3:0] OPC_HALT = 4'hF;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [31:0]       ir;
  logic [LOOP_W-1:0] loop_cnt;
  logic              error_q;

  logic [3:0]  opcode;
  logic [31:0] target;
  logic        loop_nz;
  logic        legal;
  logic        op_active;

  assign opcode  = ir[31:28];
  assign target  = {26'b0, ir[5:0]};
  assign loop_nz = |loop_cnt;
  assign legal   = (opcode == OPC_NOP) || (opcode == OPC_OP)  || (opcode == OPC_JMP) ||
                   (opcode == OPC_JNZ) || (opcode == OPC_LDC) || (opcode == OPC_HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.en) state_nxt = S_SYNC;
      S_SYNC:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal || opcode == OPC_HALT) state_nxt = S_HALT;
        else if (opcode == OPC_OP)        state_nxt = S_ISSUE;
        else                              state_nxt = S_FETCH;
      end
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (bus.op_done) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // PC controls come only from registered state, except WAIT's inc which tracks op_done.
  always_comb begin
    bus.inc      = 1'b0;
    bus.w_en     = 1'b0;
    bus.data_in  = 32'b0;
    bus.op_start = 1'b0;
    bus.complete = 1'b0;
    case (state)
      S_SYNC: bus.w_en = 1'b1;
      S_DECODE: begin
        case (opcode)
          OPC_NOP, OPC_LDC: bus.inc = 1'b1;
          OPC_JMP: begin
            bus.w_en    = 1'b1;
            bus.data_in = target;
          end
          OPC_JNZ: begin
            if (loop_nz) begin
              bus.w_en    = 1'b1;
              bus.data_in = target;
            end else begin
              bus.inc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_ISSUE: bus.op_start = 1'b1;
      S_WAIT:  bus.inc      = bus.op_done;
      S_HALT:  bus.complete = 1'b1;
      default: ;
    endcase
  end

  assign op_active   = (state == S_ISSUE) || (state == S_WAIT);
  assign bus.op_code = op_active ? ir[27:24] : 4'h0;
  assign bus.op_arg  = op_active ? ir[23:0]  : 24'h0;
  assign bus.error   = error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= 32'b0;
      loop_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= bus.instr_in;
      if (state == S_DECODE) begin
        if (opcode == OPC_LDC)            loop_cnt <= ir[LOOP_W-1:0];
        if (opcode == OPC_JNZ && loop_nz) loop_cnt <= loop_cnt - LOOP_W'(1);
        if (!legal)                       error_q  <= 1'b1;
      end
    end
  end

endmodule
